// File: rtl/apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_arbiter_if
// One APB link (select/enable/write/address/write-data/strobe one way,
// read-data/ready/error the other). The arbiter uses one instance per master
// port (slave modport) and one for the downstream bus (master modport).
//
// Handshake: a transfer is open from the cycle psel rises until the cycle in
// which pready=1 is seen at the clock edge; the requester holds
// psel/pwrite/paddr/pdata/pstb stable for that whole window and penable=1
// from its second cycle on. prdata/perr are only meaningful in the pready cycle.
//
// Signals:
//   psel, penable, pwrite   requester -> completer control
//   paddr [ADDR_WIDTH]      address
//   pdata [DATA_WIDTH]      write data
//   pstb  [4]               byte strobe
//   prdata[DATA_WIDTH]      read data (completer -> requester)
//   pready, perr            completion / error (completer -> requester)
// -----------------------------------------------------------------------------
interface apb_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pdata;
   logic [3:0]            pstb;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  perr;

   // Side that issues transfers.
   modport master (
      output psel, penable, pwrite, paddr, pdata, pstb,
      input  prdata, pready, perr
   );

   // Side that completes transfers.
   modport slave (
      input  psel, penable, pwrite, paddr, pdata, pstb,
      output prdata, pready, perr
   );
endinterface

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Two-master to one-slave APB arbiter. The granted master's transfer is
// re-issued downstream as a fresh SETUP/ACCESS pair; the other master is
// stalled (pready=0) until its turn. Contention is resolved round-robin.
// A watchdog forces an error completion when the slave never answers.
//
// Ports:
//   APB_PCLK, APB_PRESETn  clock, asynchronous active-low reset
//   m0 (slave modport)     CPU master port
//   m1 (slave modport)     secondary master port (debug loader / DMA)
//   s  (master modport)    downstream APB bus
//   grant[1:0]             one-hot current owner, 00 when idle
//   timeout_err            sticky watchdog-expiry flag
//   dbg_state[1:0]         FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// -----------------------------------------------------------------------------
module apb_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int CNT_WIDTH  = 8
) (
   input  logic           APB_PCLK,
   input  logic           APB_PRESETn,
   apb_arbiter_if.slave   m0,
   apb_arbiter_if.slave   m1,
   apb_arbiter_if.master  s,
   output logic [1:0]     grant,
   output logic           timeout_err,
   output logic [1:0]     dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam bit                   WD_EN   = (TIMEOUT != 0);
   localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_owner;        // 0 = m0, 1 = m1
   logic                  w_owner_nxt;
   logic                  r_last_grant;   // master served most recently
   logic [CNT_WIDTH-1:0]  r_wdog;
   logic                  r_timeout_err;

   logic                  w_wd_expire;
   logic                  w_done;
   logic                  w_other_req;
   logic [DATA_WIDTH-1:0] w_resp_data;
   logic                  w_resp_err;

   logic                  w_s_psel;
   logic                  w_s_penable;
   logic                  w_s_pwrite;
   logic [ADDR_WIDTH-1:0] w_s_paddr;
   logic [DATA_WIDTH-1:0] w_s_pdata;
   logic [3:0]            w_s_pstb;
   logic [1:0]            w_grant;
   logic                  w_m0_pready;
   logic                  w_m1_pready;
   logic                  w_m0_perr;
   logic                  w_m1_perr;
   logic [DATA_WIDTH-1:0] w_m0_prdata;
   logic [DATA_WIDTH-1:0] w_m1_prdata;

   // penable from the masters is not needed: a request is psel alone.
   logic                  w_unused_penable;
   assign w_unused_penable = m0.penable ^ m1.penable;

   // Expiry happens on the last permitted ACCESS cycle, only if the slave is
   // still not ready in that cycle; a real pready always takes priority.
   assign w_wd_expire = WD_EN && (r_state == ST_ACCESS) && !s.pready && (r_wdog == WD_LAST);
   assign w_done      = (r_state == ST_ACCESS) && (s.pready || w_wd_expire);
   assign w_other_req = r_owner ? m0.psel : m1.psel;
   assign w_resp_data = w_wd_expire ? '0 : s.prdata;
   assign w_resp_err  = w_wd_expire | s.perr;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
      if (!APB_PRESETn) begin
         r_state <= ST_IDLE;
         r_owner <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      case (r_state)
         ST_IDLE: begin
            if (m0.psel && m1.psel) begin
               w_state_nxt = ST_SETUP;
               w_owner_nxt = ~r_last_grant;
            end else if (m0.psel) begin
               w_state_nxt = ST_SETUP;
               w_owner_nxt = 1'b0;
            end else if (m1.psel) begin
               w_state_nxt = ST_SETUP;
               w_owner_nxt = 1'b1;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Only the other master is eligible in a completion cycle, which
            // gives back-to-back alternation under continuous contention.
            if (w_done) begin
               if (w_other_req) begin
                  w_state_nxt = ST_SETUP;
                  w_owner_nxt = ~r_owner;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      w_s_psel    = 1'b0;
      w_s_penable = 1'b0;
      w_s_pwrite  = 1'b0;
      w_s_paddr   = '0;
      w_s_pdata   = '0;
      w_s_pstb    = '0;
      w_grant     = 2'b00;
      w_m0_pready = 1'b0;
      w_m1_pready = 1'b0;
      w_m0_perr   = 1'b0;
      w_m1_perr   = 1'b0;
      w_m0_prdata = '0;
      w_m1_prdata = '0;
      if (r_state != ST_IDLE) begin
         w_s_psel    = 1'b1;
         w_s_penable = (r_state == ST_ACCESS);
         w_grant     = r_owner ? 2'b10 : 2'b01;
         if (r_owner) begin
            w_s_pwrite = m1.pwrite;
            w_s_paddr  = m1.paddr;
            w_s_pdata  = m1.pdata;
            w_s_pstb   = m1.pstb;
         end else begin
            w_s_pwrite = m0.pwrite;
            w_s_paddr  = m0.paddr;
            w_s_pdata  = m0.pdata;
            w_s_pstb   = m0.pstb;
         end
      end
      // A master that dropped psel mid-transfer has abandoned it: the
      // downstream access still finishes but the response is discarded.
      if (w_done) begin
         if (!r_owner && m0.psel) begin
            w_m0_pready = 1'b1;
            w_m0_perr   = w_resp_err;
            w_m0_prdata = w_resp_data;
         end
         if (r_owner && m1.psel) begin
            w_m1_pready = 1'b1;
            w_m1_perr   = w_resp_err;
            w_m1_prdata = w_resp_data;
         end
      end
   end

   // ------------------------------------------- round-robin history, watchdog
   always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
      if (!APB_PRESETn) begin
         r_last_grant  <= 1'b1;
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_done) begin
            r_last_grant <= r_owner;
         end
         // SETUP always precedes ACCESS, so clearing here clears on entry.
         if (r_state == ST_SETUP) begin
            r_wdog <= '0;
         end else if (WD_EN && (r_state == ST_ACCESS) && !s.pready) begin
            r_wdog <= r_wdog + CNT_WIDTH'(1);
         end
         if (w_wd_expire) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign s.psel      = w_s_psel;
   assign s.penable   = w_s_penable;
   assign s.pwrite    = w_s_pwrite;
   assign s.paddr     = w_s_paddr;
   assign s.pdata     = w_s_pdata;
   assign s.pstb      = w_s_pstb;
   assign m0.pready   = w_m0_pready;
   assign m0.perr     = w_m0_perr;
   assign m0.prdata   = w_m0_prdata;
   assign m1.pready   = w_m1_pready;
   assign m1.perr     = w_m1_perr;
   assign m1.prdata   = w_m1_prdata;
   assign grant       = w_grant;
   assign timeout_err = r_timeout_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 4;
   localparam int CW    = 8;
   localparam int REQ_W = 1 + AW + DW + 4;
   localparam int NV    = 10;
   localparam int N_RND = 24;

   // ------------------------------------------------------ clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
   apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
   apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

   logic [1:0] grant;
   logic       timeout_err;
   logic [1:0] dbg_state;

   apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .APB_PCLK    (clk),
      .APB_PRESETn (rst_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .s           (s_if),
      .grant       (grant),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected downstream transfers {pwrite, paddr, pdata, pstb} per master.
   logic [REQ_W-1:0] exp_q0[$];
   logic [REQ_W-1:0] exp_q1[$];

   typedef struct {
      bit          m0s, m0e, m1s, m1e, srdy;
      logic [31:0] srd;
      logic [1:0]  eg;
      bit          esel, een;
      logic [31:0] eaddr;
      bit          e0r, e1r;
      logic [31:0] e0d, e1d;
   } vec_t;
   vec_t vecs [NV];

   // ---------------------------------------------------------- scoreboard
   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------- drivers
   task automatic drv_m(input int m, input logic sel, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      if (m == 0) begin
         m0_if.psel = sel; m0_if.penable = en; m0_if.pwrite = wr;
         m0_if.paddr = a; m0_if.pdata = d; m0_if.pstb = b;
      end else begin
         m1_if.psel = sel; m1_if.penable = en; m1_if.pwrite = wr;
         m1_if.paddr = a; m1_if.pdata = d; m1_if.pstb = b;
      end
   endtask

   task automatic set_pen(input int m, input logic en);
      if (m == 0) m0_if.penable = en;
      else        m1_if.penable = en;
   endtask

   task automatic drv_s(input logic rdy, input logic [31:0] rd, input logic er);
      s_if.pready = rdy; s_if.prdata = rd; s_if.perr = er;
   endtask

   task automatic idle_inputs();
      drv_m(0, 0, 0, 0, 0, 0, 0);
      drv_m(1, 0, 0, 0, 0, 0, 0);
      drv_s(0, 0, 0);
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      idle_inputs();
      repeat (n) @(negedge clk);
   endtask

   function automatic logic m_sel(input int m);
      return (m == 0) ? m0_if.psel : m1_if.psel;
   endfunction
   function automatic logic m_rdy(input int m);
      return (m == 0) ? m0_if.pready : m1_if.pready;
   endfunction
   function automatic logic m_err(input int m);
      return (m == 0) ? m0_if.perr : m1_if.perr;
   endfunction
   function automatic logic [31:0] m_rd(input int m);
      return (m == 0) ? m0_if.prdata : m1_if.prdata;
   endfunction

   function automatic vec_t mk(bit m0s, bit m0e, bit m1s, bit m1e, bit srdy, logic [31:0] srd,
                               logic [1:0] eg, bit esel, bit een, logic [31:0] eaddr,
                               bit e0r, bit e1r, logic [31:0] e0d, logic [31:0] e1d);
      vec_t v;
      v.m0s = m0s; v.m0e = m0e; v.m1s = m1s; v.m1e = m1e; v.srdy = srdy; v.srd = srd;
      v.eg = eg; v.esel = esel; v.een = een; v.eaddr = eaddr;
      v.e0r = e0r; v.e1r = e1r; v.e0d = e0d; v.e1d = e1d;
      return v;
   endfunction

   // ---------------------------------------------------- randomized phase
   // Reference model at transaction level: whenever the arbiter is free
   // (idle, or a completion happened), the next cycle's owner is decided from
   // the masters that were requesting (minus the one just served), favouring
   // the master that was not served last.
   task automatic run_random();
      int m_st[2];
      int gap[2];
      int left[2];
      int done_cnt[2];
      bit got_rdy[2];
      bit prev_req[2];
      bit prev_free, c0, c1, busy, done;
      int prev_done, last_served, owner, s_wait, exp_o;
      logic [REQ_W-1:0] cur, front;
      logic [31:0] s_rd;
      logic s_er, s_rdy;
      for (int m = 0; m < 2; m++) begin
         m_st[m] = 0; gap[m] = $urandom_range(0, 3); left[m] = N_RND;
         done_cnt[m] = 0; got_rdy[m] = 0; prev_req[m] = 0;
      end
      prev_free = 1; prev_done = -1; last_served = 1; owner = 0; s_wait = -1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (left[0] == 0 && left[1] == 0 && m_st[0] == 0 && m_st[1] == 0) break;
         @(posedge clk); #1;
         for (int m = 0; m < 2; m++) begin
            case (m_st[m])
               0: begin
                  if (gap[m] > 0) gap[m]--;
                  else if (left[m] > 0) begin
                     cur = {1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom)};
                     if (m == 0) exp_q0.push_back(cur); else exp_q1.push_back(cur);
                     drv_m(m, 1, 0, cur[68], cur[67:36], cur[35:4], cur[3:0]);
                     m_st[m] = 1; left[m]--;
                  end
               end
               1: begin set_pen(m, 1); m_st[m] = 2; end
               default: begin
                  if (got_rdy[m]) begin
                     drv_m(m, 0, 0, 0, 0, 0, 0);
                     got_rdy[m] = 0; m_st[m] = 0; gap[m] = $urandom_range(0, 3);
                  end
               end
            endcase
         end
         // Slave: 0..2 wait states; pready outside ACCESS is random noise.
         if (s_if.psel && s_if.penable) begin
            if (s_wait < 0) s_wait = $urandom_range(0, 2);
            s_rdy = (s_wait == 0);
            if (s_rdy) s_wait = -1; else s_wait--;
         end else begin
            s_rdy = 1'($urandom_range(0, 1));
         end
         s_rd = $urandom; s_er = 1'($urandom_range(0, 1));
         drv_s(s_rdy, s_rd, s_er);
         @(negedge clk);
         chk("rnd_grant_not_11", (grant == 2'b11), 0);
         c0 = prev_req[0] && (prev_done != 0);
         c1 = prev_req[1] && (prev_done != 1);
         if (prev_free) begin
            busy = c0 || c1;
            if (!busy) begin
               chk("rnd_idle_psel", s_if.psel, 0);
               chk("rnd_idle_grant", grant, 2'b00);
            end else begin
               exp_o = (c0 && c1) ? (1 - last_served) : (c0 ? 0 : 1);
               owner = exp_o;
               chk("rnd_setup_phase", {s_if.psel, s_if.penable}, 2'b10);
               chk("rnd_setup_grant", grant, (exp_o == 1) ? 2'b10 : 2'b01);
            end
         end else begin
            busy = 1;
            chk("rnd_access_phase", {s_if.psel, s_if.penable}, 2'b11);
            chk("rnd_access_grant", grant, (owner == 1) ? 2'b10 : 2'b01);
         end
         done = !prev_free && s_rdy;
         for (int m = 0; m < 2; m++) begin
            chk($sformatf("rnd_m%0d_pready", m), m_rdy(m), done && (m == owner));
            if (done && m == owner) begin
               chk($sformatf("rnd_m%0d_prdata", m), m_rd(m), s_rd);
               chk($sformatf("rnd_m%0d_perr", m), m_err(m), s_er);
               if ((m == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                  chk("rnd_queue_underflow", 1, 0);
               end else begin
                  front = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  chk($sformatf("rnd_m%0d_downstream", m),
                      {s_if.pwrite, s_if.paddr, s_if.pdata, s_if.pstb}, front);
               end
            end else begin
               chk($sformatf("rnd_m%0d_perr_idle", m), m_err(m), 0);
            end
         end
         for (int m = 0; m < 2; m++) prev_req[m] = m_sel(m);
         prev_done = done ? owner : -1;
         if (done) begin
            last_served = owner; got_rdy[owner] = 1; done_cnt[owner]++;
         end
         prev_free = !busy || done;
      end
      chk("rnd_m0_done_count", done_cnt[0], N_RND);
      chk("rnd_m1_done_count", done_cnt[1], N_RND);
      chk("rnd_queues_empty", exp_q0.size() + exp_q1.size(), 0);
      idle_inputs();
   endtask

   // ---------------------------------------------------------- main test
   initial begin
      int order[$];
      bit rs[2];
      int idle_cnt;
      bit started;
      vec_t v;

      vecs[0] = mk(1,0,1,0, 0, 32'h0,        2'b00, 0,0, 32'h0,   0,0, 32'h0, 32'h0);
      vecs[1] = mk(1,1,1,1, 0, 32'h0,        2'b01, 1,0, 32'h100, 0,0, 32'h0, 32'h0);
      vecs[2] = mk(1,1,1,1, 1, 32'hCAFE0001, 2'b01, 1,1, 32'h100, 1,0, 32'hCAFE0001, 32'h0);
      vecs[3] = mk(0,0,1,1, 0, 32'h0,        2'b10, 1,0, 32'h200, 0,0, 32'h0, 32'h0);
      vecs[4] = mk(0,0,1,1, 1, 32'h0BADF00D, 2'b10, 1,1, 32'h200, 0,1, 32'h0, 32'h0BADF00D);
      vecs[5] = mk(0,0,0,0, 0, 32'h0,        2'b00, 0,0, 32'h0,   0,0, 32'h0, 32'h0);
      vecs[6] = mk(1,0,0,0, 1, 32'hDEADBEEF, 2'b00, 0,0, 32'h0,   0,0, 32'h0, 32'h0);
      vecs[7] = mk(1,1,0,0, 1, 32'hDEADBEEF, 2'b01, 1,0, 32'h100, 0,0, 32'h0, 32'h0);
      vecs[8] = mk(1,1,0,0, 1, 32'hDEADBEEF, 2'b01, 1,1, 32'h100, 1,0, 32'hDEADBEEF, 32'h0);
      vecs[9] = mk(0,0,0,0, 0, 32'h0,        2'b00, 0,0, 32'h0,   0,0, 32'h0, 32'h0);

      // Reset state
      idle_inputs();
      #12;
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_ctrl", {s_if.psel, s_if.penable, s_if.pwrite}, 3'b000);
      chk("rst_s_bus", {s_if.paddr, s_if.pdata, s_if.pstb}, 0);
      chk("rst_m_resp", {m0_if.pready, m0_if.perr, m1_if.pready, m1_if.perr}, 4'b0000);
      chk("rst_m_rdata", {m0_if.prdata, m1_if.prdata}, 0);
      chk("rst_timeout_err", timeout_err, 0);
      @(negedge clk); rst_n = 1'b1;

      // Tie right after reset (m0 first), then single uncontended m0 read.
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         @(posedge clk); #1;
         drv_m(0, v.m0s, v.m0e, 0, 32'h100, 32'h0, 4'hF);
         drv_m(1, v.m1s, v.m1e, 0, 32'h200, 32'h0, 4'hF);
         drv_s(v.srdy, v.srd, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_grant", i), grant, v.eg);
         chk($sformatf("vec%0d_s_ctrl", i), {s_if.psel, s_if.penable}, {v.esel, v.een});
         chk($sformatf("vec%0d_s_paddr", i), s_if.paddr, v.eaddr);
         chk($sformatf("vec%0d_pready", i), {m0_if.pready, m1_if.pready}, {v.e0r, v.e1r});
         chk($sformatf("vec%0d_m0_prdata", i), m0_if.prdata, v.e0d);
         chk($sformatf("vec%0d_m1_prdata", i), m1_if.prdata, v.e1d);
      end
      idle_cycles(2);

      // m1 write, 3 slave wait states
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         drv_m(1, 1, (c >= 1), 1, 32'h1004, 32'h12345678, 4'b0011);
         drv_s((c == 5), 32'h0, 0);
         @(negedge clk);
         chk($sformatf("wr_c%0d_s_ctrl", c), {s_if.psel, s_if.penable}, {(c >= 1), (c >= 2)});
         chk($sformatf("wr_c%0d_m1_pready", c), m1_if.pready, (c == 5));
         if (c >= 1) begin
            chk($sformatf("wr_c%0d_grant", c), grant, 2'b10);
            chk($sformatf("wr_c%0d_s_bus", c), {s_if.pwrite, s_if.paddr, s_if.pdata, s_if.pstb},
                {1'b1, 32'h1004, 32'h12345678, 4'b0011});
         end
      end
      chk("wr_m1_perr", m1_if.perr, 0);
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      chk("wr_after_idle", s_if.psel, 0);
      idle_cycles(1);

      // Watchdog: slave never ready
      chk("to_flag_before", timeout_err, 0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         drv_m(0, 1, (c >= 1), 0, 32'h300, 32'h0, 4'hF);
         drv_s(0, 32'h55AA55AA, 0);
         @(negedge clk);
         chk($sformatf("to_c%0d_m0_pready", c), m0_if.pready, (c == 5));
         if (c == 5) begin
            chk("to_m0_perr", m0_if.perr, 1);
            chk("to_m0_prdata", m0_if.prdata, 0);
         end
      end
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      chk("to_released", {s_if.psel, s_if.penable}, 2'b00);
      chk("to_flag_set", timeout_err, 1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         drv_m(1, 1, (c >= 1), 0, 32'h304, 32'h0, 4'hF);
         drv_s(1, 32'h55AA55AA, 0);
         @(negedge clk);
         chk($sformatf("to_m1_c%0d_pready", c), m1_if.pready, (c == 2));
      end
      chk("to_m1_perr", m1_if.perr, 0);
      chk("to_m1_prdata", m1_if.prdata, 32'h55AA55AA);
      chk("to_flag_sticky", timeout_err, 1);
      idle_cycles(2);

      // Reset during ACCESS with slave waiting
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         drv_m(0, 1, (c >= 1), 0, 32'h500, 32'h0, 4'hF);
         drv_s(0, 32'h0, 0);
         @(negedge clk);
      end
      chk("rm_in_access", {s_if.psel, s_if.penable}, 2'b11);
      #2; rst_n = 1'b0; #1;
      chk("rm_grant", grant, 2'b00);
      chk("rm_s_ctrl", {s_if.psel, s_if.penable}, 2'b00);
      chk("rm_s_paddr", s_if.paddr, 0);
      chk("rm_m0_resp", {m0_if.pready, m0_if.perr, m0_if.prdata}, 0);
      chk("rm_flag_cleared", timeout_err, 0);
      drv_m(0, 1, 0, 0, 32'h600, 32'h0, 4'hF);
      drv_m(1, 1, 0, 0, 32'h700, 32'h0, 4'hF);
      @(negedge clk);
      chk("rm_held_grant", grant, 2'b00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rm_first_grant", grant, 2'b01);
      @(posedge clk); #1;
      set_pen(0, 1); set_pen(1, 1); drv_s(1, 32'h0, 0);
      @(negedge clk);
      chk("rm_m0_done", {m0_if.pready, m1_if.pready}, 2'b10);
      @(posedge clk); #1; drv_m(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rm_second_grant", grant, 2'b10);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rm_m1_done", {m0_if.pready, m1_if.pready}, 2'b01);
      idle_cycles(2);

      // Continuous contention, six transfers
      do_reset();
      idle_cnt = 0; started = 0; rs[0] = 0; rs[1] = 0;
      for (int c = 0; c < 40 && order.size() < 6; c++) begin
         @(posedge clk); #1;
         for (int m = 0; m < 2; m++) begin
            if (c == 0 || rs[m]) begin
               drv_m(m, 1, 0, 0, 32'h400 + 32'(m * 16), 32'h0, 4'hF);
               rs[m] = 0;
            end else begin
               set_pen(m, 1);
            end
         end
         drv_s(1, 32'h600D0000 + 32'(c), 0);
         @(negedge clk);
         if (started && !s_if.psel) idle_cnt++;
         if (s_if.psel) started = 1;
         if (m0_if.pready) begin order.push_back(0); rs[0] = 1; end
         if (m1_if.pready) begin order.push_back(1); rs[1] = 1; end
      end
      chk("alt_count", order.size(), 6);
      for (int i = 0; i < order.size(); i++) chk($sformatf("alt_order%0d", i), order[i], i % 2);
      chk("alt_idle_cycles", idle_cnt, 0);
      // m0 is granted again but abandons its request: no response reaches it.
      @(posedge clk); #1;
      drv_m(0, 0, 0, 0, 0, 0, 0);
      drv_m(1, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abandon_c%0d_pready", c), {m0_if.pready, m1_if.pready}, 2'b00);
      end
      chk("abandon_idle", s_if.psel, 0);
      idle_cycles(2);

      // Randomized traffic against the reference model
      do_reset();
      run_random();
      idle_cycles(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: actual=expired required=finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-master to one-slave APB arbiter on the APB_PCLK domain.
- Port m0 is the CPU APB master; port m1 is a secondary master (debug loader / DMA).
- The block re-issues the granted master's transfer on the downstream APB bus (s_*) as a fresh SETUP/ACCESS sequence, stalls the other master via pready=0, and uses round-robin on contention.
- A watchdog terminates any downstream access whose slave never asserts pready.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT, 255, max ACCESS cycles before forced error completion; 0 disables the watchdog
CNT_WIDTH, 8, watchdog counter width; must hold TIMEOUT

Ports:
APB_PCLK  in  1  clock
APB_PRESETn  in  1  asynchronous active-low reset
mN_psel  in  1  master N select (N = 0, 1; each mN_* port exists for both masters)
mN_penable  in  1  master N enable
mN_pwrite  in  1  master N write
mN_paddr  in  ADDR_WIDTH  master N address
mN_pdata  in  DATA_WIDTH  master N write data
mN_pstb  in  4  master N byte strobe
mN_prdata  out  DATA_WIDTH  read data to master N
mN_pready  out  1  completion to master N
mN_perr  out  1  error to master N
s_psel  out  1  downstream select
s_penable  out  1  downstream enable
s_pwrite  out  1  downstream write
s_paddr  out  ADDR_WIDTH  downstream address
s_pdata  out  DATA_WIDTH  downstream write data
s_pstb  out  4  downstream strobe
s_prdata  in  DATA_WIDTH  downstream read data
s_pready  in  1  downstream ready
s_perr  in  1  downstream error
grant  out  2  one-hot current owner; 00 when idle
timeout_err  out  1  sticky: a watchdog expiry occurred

Behaviour:
- Reset (async, APB_PRESETn=0):
  - state=IDLE; grant=00; last_grant=1, so m0 wins the first tie; watchdog=0; timeout_err=0.
  - All s_* outputs 0; all mN_pready/mN_perr 0; mN_prdata 0.
  - Reset asserted mid-transfer aborts the transfer immediately; no completion is delivered to any master.
- States:
  - IDLE: no owner. A request is mN_psel=1 sampled at the clock edge. Exactly one requester: grant it. Both requesting: grant the master != last_grant. On grant, go to SETUP.
  - SETUP (1 cycle): s_psel=1, s_penable=0, s_* driven combinationally from the owner's inputs. Next state is ACCESS.
  - ACCESS: s_psel=1, s_penable=1. Completion is s_pready=1, or watchdog expiry.
- Completion cycle:
  - Owner's mN_pready=1 combinationally. mN_prdata=s_prdata and mN_perr=s_perr, both muxed to the owner only.
  - last_grant is set to the owner.
  - If the other master's psel=1, go directly to SETUP with the other master granted (back-to-back, no IDLE bubble). Otherwise go to IDLE.
  - The completing master is not eligible for a grant in its own completion cycle.
- Non-owner: mN_pready=0 and mN_perr=0 at all times; its psel/penable are held pending and it waits.
- Latency:
  - Uncontended request with zero-wait slave: master SETUP at cycle T, arbiter SETUP T+1, ACCESS T+2, mN_pready at T+2 (one added cycle).
  - Each slave wait state adds one cycle.
- Watchdog:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with s_pready=0.
  - When TIMEOUT!=0 and counter==TIMEOUT-1 with s_pready=0, that cycle becomes a forced completion: owner gets pready=1, perr=1, prdata=0. timeout_err sets and stays set until reset.
  - s_psel/s_penable drop the next cycle, as in a normal completion.
- Owner inputs are not registered: masters hold addr/data/strobe stable per APB. A master deasserting psel while granted but before completion is a protocol violation; the arbiter completes the downstream transfer and discards the response.
- grant changes only on state transitions. It is never 11.

Test Plan:
- Single m0 read, slave zero-wait, s_prdata=0xDEADBEEF: m0 sees pready at its 3rd cycle with prdata=0xDEADBEEF; grant=01 for 2 cycles; m1_pready stays 0.
- m0 and m1 request in the same cycle just after reset: m0 served first (last_grant=1). m1 starts SETUP the cycle after m0 completes; grant sequence 01,01,10,10,00.
- Continuous requests from both masters, 6 transfers: grants strictly alternate m0,m1,m0,m1,m0,m1; no IDLE cycles between transfers.
- m1 write to 0x1004, data 0x12345678, pstb=0011, slave with 3 wait states: s_paddr/s_pdata/s_pstb match and s_pwrite=1 throughout; m1_pready asserted after 3 ACCESS wait cycles.
- TIMEOUT=4, slave never ready: m0_pready=m0_perr=1 on the 4th ACCESS cycle; timeout_err=1 sticky; next m1 request is still served normally.
- Assert APB_PRESETn=0 during ACCESS with slave waiting: all outputs 0 asynchronously, grant=00. After release, m0 and m1 requesting together: m0 granted first.
